cpu_step_ctrl: RTL



---
 rtl/lib_cpu_pkg.sv | 18 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/cpu_step_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lib_cpu_pkg.sv
// rtl/lib_cpu_pkg.sv - shared CPU package: controller state type and step counter width
package lib_cpu;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } CTRL_STATE;

  localparam int STEP_CNT_W = 8;

  // HALT and BREAK both present the CPU as stopped to the board
  function automatic logic is_stopped(input CTRL_STATE s);
    return (s == HALT) || (s == BREAK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, stable-level debouncer and press pulse generator
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser feeding a counter of consecutive samples that differ
  // from the accepted level; the level flips after DEBOUNCE_CYCLES of them and
  // only a 0->1 flip produces a press pulse.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU execution sequencer (halt/run/step/breakpoint); step counter under CPU_STEP_COUNT_EN
module cpu_step_ctrl
  import lib_cpu::*;
#(
  parameter int CLK_DIV         = 12_000_000,
  parameter int DIV_FAST        = 1_200_000,
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int IP_W            = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  btn_run,
  input  logic                  btn_step,
  input  logic                  fast_sel,
  input  logic                  bp_en,
  input  logic [IP_W-1:0]       bp_addr,
  input  logic [IP_W-1:0]       cpu_ip,
  output logic                  cpu_en,
  output logic [1:0]            state,
  output logic                  halted,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam int PRE_MAX = (CLK_DIV > DIV_FAST) ? CLK_DIV : DIV_FAST;
  localparam int PRE_W   = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
  localparam logic [PRE_W-1:0] SLOW_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] FAST_LAST = PRE_W'(DIV_FAST - 1);

  logic             run_press;
  logic             step_press;
  CTRL_STATE        state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             halted_q;
  logic             bp_skip_q, bp_skip_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pre_last;
  logic             tick;
  logic             bp_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk     (clk),
    .n_reset (n_reset),
    .btn     (btn_run),
    .press   (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk     (clk),
    .n_reset (n_reset),
    .btn     (btn_step),
    .press   (step_press)
  );

  // A >= compare lets a rate switch to a shorter period tick at once
  assign pre_last = fast_sel ? FAST_LAST : SLOW_LAST;
  assign tick     = (pre_q >= pre_last);
  assign bp_hit   = bp_en && (cpu_ip == bp_addr) && !bp_skip_q;

  // Next state, next enable and prescaler/skip updates; run wins over step
  always_comb begin
    state_d   = state_q;
    cpu_en_d  = 1'b0;
    bp_skip_d = bp_skip_q;
    pre_d     = pre_q;
    case (state_q)
      HALT, BREAK: begin
        if (run_press) begin
          state_d   = RUN;
          bp_skip_d = 1'b1;
          pre_d     = '0;
        end else if (step_press) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
      STEP: begin
        state_d = HALT;
      end
      RUN: begin
        if (run_press) begin
          state_d = HALT;
        end else if (tick) begin
          pre_d = '0;
          if (bp_hit) begin
            state_d = BREAK;
          end else begin
            cpu_en_d  = 1'b1;
            bp_skip_d = 1'b0;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Controller registers; all outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= HALT;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b1;
      bp_skip_q <= 1'b0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      halted_q  <= is_stopped(state_d);
      bp_skip_q <= bp_skip_d;
      pre_q     <= pre_d;
    end
  end

  assign cpu_en = cpu_en_q;
  assign state  = state_q;
  assign halted = halted_q;

`ifdef CPU_STEP_COUNT_EN
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  // Count executed instructions, holding at all-ones
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (cpu_en_q && (step_cnt_q != '1)) begin
      step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
    end
  end

  // Step counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt = step_cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule
